// File: rtl/trap_ctrl.sv
// trap_ctrl: picks one exception, MRET or interrupt in IDLE, flushes the pipe, commits to the CSR file, redirects fetch.
// Optional feature macro VECTORED_MTVEC_EN: vectored interrupt targets when mtvec[1:0] == 2'b01.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_exc_valid,
  input  logic [4:0]  i_exc_cause,
  input  logic [31:0] i_exc_pc,
  input  logic        i_mret_req,
  input  logic        i_irq_ext,
  input  logic        i_irq_timer,
  input  logic        i_irq_sw,
  input  logic [31:0] i_int_pc,
  input  logic        i_int_ok,
  input  logic        i_mstatus_mie,
  input  logic [31:0] i_mie,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic        i_pipe_drained,
  input  logic        i_redirect_ready,
  output logic        o_busy,
  output logic        o_flush,
  output logic        o_trap_taken,
  output logic [31:0] o_trap_cause,
  output logic [31:0] o_trap_pc,
  output logic        o_mret_taken,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned MIE_SW  = 3;
  localparam int unsigned MIE_TIM = 7;
  localparam int unsigned MIE_EXT = 11;

  localparam logic [CODE_W-1:0] CODE_SW  = CODE_W'(3);
  localparam logic [CODE_W-1:0] CODE_TIM = CODE_W'(7);
  localparam logic [CODE_W-1:0] CODE_EXT = CODE_W'(11);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched event payload
  logic            r_is_mret;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_target;

  // Output registers
  logic            r_busy;
  logic            r_flush;
  logic            r_trap_taken;
  logic            r_mret_taken;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_trap_cause;
  logic [XLEN-1:0] r_trap_pc;
  logic [XLEN-1:0] r_redirect_pc;

  logic            w_busy_nxt;
  logic            w_flush_nxt;
  logic            w_trap_taken_nxt;
  logic            w_mret_taken_nxt;
  logic            w_redirect_valid_nxt;
  logic [XLEN-1:0] w_trap_cause_nxt;
  logic [XLEN-1:0] w_trap_pc_nxt;
  logic [XLEN-1:0] w_redirect_pc_nxt;

  // Interrupt pending set and fixed priority ext > sw > timer
  logic              w_pend_ext;
  logic              w_pend_sw;
  logic              w_pend_tim;
  logic              w_irq_take;
  logic [CODE_W-1:0] w_irq_code;

  assign w_pend_ext = i_irq_ext   & i_mie[MIE_EXT];
  assign w_pend_sw  = i_irq_sw    & i_mie[MIE_SW];
  assign w_pend_tim = i_irq_timer & i_mie[MIE_TIM];
  assign w_irq_take = i_mstatus_mie & i_int_ok & (w_pend_ext | w_pend_sw | w_pend_tim);

  always_comb begin
    w_irq_code = CODE_TIM;
    if (w_pend_ext) begin
      w_irq_code = CODE_EXT;
    end else if (w_pend_sw) begin
      w_irq_code = CODE_SW;
    end
  end

  // Event selection: exception > MRET > interrupt
  logic w_sel_exc;
  logic w_sel_mret;
  logic w_accept;

  assign w_sel_exc  = i_exc_valid;
  assign w_sel_mret = ~i_exc_valid & i_mret_req;
  assign w_accept   = i_exc_valid | i_mret_req | w_irq_take;

  logic [XLEN-1:0] w_ev_cause;
  logic [XLEN-1:0] w_ev_pc;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_target;
  logic [XLEN-1:0] w_mret_target;

  assign w_ev_cause = w_sel_exc ? {27'b0, i_exc_cause} : {1'b1, 26'b0, w_irq_code};
  assign w_ev_pc    = w_sel_exc ? i_exc_pc : i_int_pc;
  assign w_base     = {i_mtvec[31:2], 2'b00};

`ifdef VECTORED_MTVEC_EN
  // Only interrupts vector; exceptions always land on the base address
  assign w_trap_target = (!w_sel_exc && (i_mtvec[1:0] == 2'b01))
                       ? w_base + (XLEN'(w_irq_code) << 2)
                       : w_base;
`else
  assign w_trap_target = w_base;
`endif

  // mepc is taken as seen in COMMIT, before the CSR file applies the same-cycle update
  assign w_mret_target = {i_mepc[31:2], 2'b00};

  logic w_unused;
  assign w_unused = &{1'b0, i_mie[31:12], i_mie[10:8], i_mie[6:4], i_mie[2:0],
                      i_mtvec[1:0], i_mepc[1:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (i_pipe_drained) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (i_redirect_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic, evaluated against the next state so every output comes from a flop
  always_comb begin
    w_busy_nxt           = (w_state_nxt != S_IDLE);
    w_flush_nxt          = (w_state_nxt == S_FLUSH);
    w_trap_taken_nxt     = (w_state_nxt == S_COMMIT) & ~r_is_mret;
    w_mret_taken_nxt     = (w_state_nxt == S_COMMIT) &  r_is_mret;
    w_redirect_valid_nxt = (w_state_nxt == S_REDIRECT);
    w_trap_cause_nxt     = r_trap_cause;
    w_trap_pc_nxt        = r_trap_pc;
    w_redirect_pc_nxt    = r_redirect_pc;
    if (w_trap_taken_nxt) begin
      w_trap_cause_nxt = r_cause;
      w_trap_pc_nxt    = r_epc;
    end
    if (r_state == S_COMMIT) begin
      w_redirect_pc_nxt = r_is_mret ? w_mret_target : r_target;
    end
  end

  // Event payload capture on acceptance in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_mret <= 1'b0;
      r_cause   <= '0;
      r_epc     <= '0;
      r_target  <= '0;
    end else if ((r_state == S_IDLE) && w_accept) begin
      r_is_mret <= w_sel_mret;
      r_cause   <= w_ev_cause;
      r_epc     <= w_ev_pc;
      r_target  <= w_trap_target;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy           <= 1'b0;
      r_flush          <= 1'b0;
      r_trap_taken     <= 1'b0;
      r_mret_taken     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_trap_cause     <= '0;
      r_trap_pc        <= '0;
      r_redirect_pc    <= '0;
    end else begin
      r_busy           <= w_busy_nxt;
      r_flush          <= w_flush_nxt;
      r_trap_taken     <= w_trap_taken_nxt;
      r_mret_taken     <= w_mret_taken_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_trap_cause     <= w_trap_cause_nxt;
      r_trap_pc        <= w_trap_pc_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
    end
  end

  assign o_busy           = r_busy;
  assign o_flush          = r_flush;
  assign o_trap_taken     = r_trap_taken;
  assign o_mret_taken     = r_mret_taken;
  assign o_redirect_valid = r_redirect_valid;
  assign o_trap_cause     = r_trap_cause;
  assign o_trap_pc        = r_trap_pc;
  assign o_redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and random transactions against a transaction-level model of trap_ctrl.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_exc_valid;
  logic [4:0]  i_exc_cause;
  logic [31:0] i_exc_pc;
  logic        i_mret_req;
  logic        i_irq_ext;
  logic        i_irq_timer;
  logic        i_irq_sw;
  logic [31:0] i_int_pc;
  logic        i_int_ok;
  logic        i_mstatus_mie;
  logic [31:0] i_mie;
  logic [31:0] i_mtvec;
  logic [31:0] i_mepc;
  logic        i_pipe_drained;
  logic        i_redirect_ready;
  logic        o_busy;
  logic        o_flush;
  logic        o_trap_taken;
  logic [31:0] o_trap_cause;
  logic [31:0] o_trap_pc;
  logic        o_mret_taken;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;

  trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .i_exc_valid      (i_exc_valid),
    .i_exc_cause      (i_exc_cause),
    .i_exc_pc         (i_exc_pc),
    .i_mret_req       (i_mret_req),
    .i_irq_ext        (i_irq_ext),
    .i_irq_timer      (i_irq_timer),
    .i_irq_sw         (i_irq_sw),
    .i_int_pc         (i_int_pc),
    .i_int_ok         (i_int_ok),
    .i_mstatus_mie    (i_mstatus_mie),
    .i_mie            (i_mie),
    .i_mtvec          (i_mtvec),
    .i_mepc           (i_mepc),
    .i_pipe_drained   (i_pipe_drained),
    .i_redirect_ready (i_redirect_ready),
    .o_busy           (o_busy),
    .o_flush          (o_flush),
    .o_trap_taken     (o_trap_taken),
    .o_trap_cause     (o_trap_cause),
    .o_trap_pc        (o_trap_pc),
    .o_mret_taken     (o_mret_taken),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        is_mret;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] target;
  } ev_t;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  bit          quiet    = 1'b0;
  logic [31:0] m_cause  = '0;
  logic [31:0] m_pc     = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_exc_valid = 0; i_exc_cause = '0; i_exc_pc = '0; i_mret_req = 0;
    i_irq_ext = 0; i_irq_timer = 0; i_irq_sw = 0; i_int_pc = '0; i_int_ok = 0;
    i_mstatus_mie = 0; i_mie = '0; i_mtvec = '0; i_mepc = '0;
    i_pipe_drained = 0; i_redirect_ready = 0;
  endtask

  // Random values on every input; requests outside IDLE must have no effect
  task automatic scramble();
    if (quiet) return;
    i_exc_valid   = 1'($urandom);  i_exc_cause = 5'($urandom); i_exc_pc = $urandom;
    i_mret_req    = 1'($urandom);  i_irq_ext = 1'($urandom);   i_irq_timer = 1'($urandom);
    i_irq_sw      = 1'($urandom);  i_int_pc = $urandom;        i_int_ok = 1'($urandom);
    i_mstatus_mie = 1'($urandom);  i_mie = $urandom;           i_mtvec = $urandom;
    i_mepc        = $urandom;      i_pipe_drained = 1'($urandom);
    i_redirect_ready = 1'($urandom);
  endtask

  task automatic random_idle_inputs();
    i_exc_valid   = ($urandom_range(0, 3) == 0);
    i_exc_cause   = 5'($urandom);
    i_exc_pc      = $urandom;
    i_mret_req    = ($urandom_range(0, 3) == 0);
    i_irq_ext     = 1'($urandom);
    i_irq_timer   = 1'($urandom);
    i_irq_sw      = 1'($urandom);
    i_int_pc      = $urandom;
    i_int_ok      = ($urandom_range(0, 3) != 0);
    i_mstatus_mie = ($urandom_range(0, 3) != 0);
    i_mie         = $urandom;
    i_mtvec       = $urandom;
    i_mepc        = $urandom;
    if ($urandom_range(0, 3) == 0) i_mtvec[1:0] = 2'b01;
    i_pipe_drained   = 1'($urandom);
    i_redirect_ready = 1'($urandom);
  endtask

  // Reference: which event the current IDLE-cycle inputs select
  function automatic ev_t predict();
    ev_t e;
    int  code;
    e = '0;
    code = -1;
    if (i_exc_valid) begin
      e.valid = 1; e.cause = 32'(i_exc_cause); e.pc = i_exc_pc;
      e.target = i_mtvec & 32'hFFFF_FFFC;
    end else if (i_mret_req) begin
      e.valid = 1; e.is_mret = 1;
    end else if (i_mstatus_mie && i_int_ok) begin
      if (i_irq_ext && i_mie[11])      code = 11;
      else if (i_irq_sw && i_mie[3])   code = 3;
      else if (i_irq_timer && i_mie[7]) code = 7;
      if (code >= 0) begin
        e.valid = 1; e.cause = 32'h8000_0000 + 32'(code); e.pc = i_int_pc;
        e.target = i_mtvec & 32'hFFFF_FFFC;
`ifdef VECTORED_MTVEC_EN
        if (i_mtvec[1:0] == 2'b01) e.target = e.target + 32'(4 * code);
`endif
      end
    end
    return e;
  endfunction

  task automatic chk_hold(input string tag);
    chk({tag, "_cause_hold"}, o_trap_cause, m_cause);
    chk({tag, "_pc_hold"},    o_trap_pc,    m_pc);
  endtask

  // One IDLE decision and, if an event is taken, its complete flush/commit/redirect sequence
  task automatic run_txn(input int drain_dly, input int rdy_dly, output logic [31:0] obs_rpc);
    ev_t e;
    e = predict();
    obs_rpc = '0;
    @(posedge clk); #1;
    if (!e.valid) begin
      chk("noev_busy", 32'(o_busy), 0);
      chk("noev_flush", 32'(o_flush), 0);
      chk("noev_redir", 32'(o_redirect_valid), 0);
      chk_hold("noev");
      return;
    end
    for (int i = 0; i <= drain_dly; i++) begin
      chk("flush_flush", 32'(o_flush), 1);
      chk("flush_busy", 32'(o_busy), 1);
      chk("flush_trap", 32'(o_trap_taken), 0);
      chk("flush_mret", 32'(o_mret_taken), 0);
      chk("flush_redir", 32'(o_redirect_valid), 0);
      chk_hold("flush");
      scramble();
      i_pipe_drained = (i == drain_dly);
      @(posedge clk); #1;
    end
    if (!e.is_mret) begin
      m_cause = e.cause;
      m_pc    = e.pc;
    end
    chk("commit_trap", 32'(o_trap_taken), 32'(!e.is_mret));
    chk("commit_mret", 32'(o_mret_taken), 32'(e.is_mret));
    chk("commit_busy", 32'(o_busy), 1);
    chk("commit_flush", 32'(o_flush), 0);
    chk_hold("commit");
    scramble();
    if (e.is_mret) e.target = i_mepc & 32'hFFFF_FFFC;
    @(posedge clk); #1;
    obs_rpc = o_redirect_pc;
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("redir_valid", 32'(o_redirect_valid), 1);
      chk("redir_pc", o_redirect_pc, e.target);
      chk("redir_busy", 32'(o_busy), 1);
      chk("redir_trap", 32'(o_trap_taken), 0);
      chk("redir_mret", 32'(o_mret_taken), 0);
      chk_hold("redir");
      scramble();
      i_redirect_ready = (i == rdy_dly);
      @(posedge clk); #1;
    end
    chk("ret_busy", 32'(o_busy), 0);
    chk("ret_redir", 32'(o_redirect_valid), 0);
    chk("ret_flush", 32'(o_flush), 0);
    chk("ret_trap", 32'(o_trap_taken), 0);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_flush", 32'(o_flush), 0);
    chk("rst_trap", 32'(o_trap_taken), 0);
    chk("rst_mret", 32'(o_mret_taken), 0);
    chk("rst_redir", 32'(o_redirect_valid), 0);
    chk("rst_cause", o_trap_cause, 0);
    chk("rst_tpc", o_trap_pc, 0);
    chk("rst_rpc", o_redirect_pc, 0);
    rst = 1'b0;

    quiet = 1'b1;
    // Basic synchronous exception
    clear_inputs();
    i_exc_valid = 1; i_exc_cause = 5'd2; i_exc_pc = 32'h100; i_mtvec = 32'h200;
    i_pipe_drained = 1;
    run_txn(0, 0, rpc);
    chk("r38_cause", o_trap_cause, 32'h2);
    chk("r38_tpc", o_trap_pc, 32'h100);
    chk("r38_rpc", rpc, 32'h200);

    // Exception beats MRET and interrupt in the same cycle
    clear_inputs();
    i_exc_valid = 1; i_exc_cause = 5'd13; i_exc_pc = 32'h4000; i_mret_req = 1;
    i_irq_ext = 1; i_mie = 32'h800; i_mstatus_mie = 1; i_int_ok = 1; i_mtvec = 32'h800;
    run_txn(2, 1, rpc);
    chk("r39_cause", o_trap_cause, 32'hD);
    chk("r39_rpc", rpc, 32'h800);

    // sw beats timer; then the same lines masked by mstatus.mie
    clear_inputs();
    i_irq_timer = 1; i_irq_sw = 1; i_mie = 32'h88; i_mstatus_mie = 1; i_int_ok = 1;
    i_int_pc = 32'h40; i_mtvec = 32'h1000;
    run_txn(1, 0, rpc);
    chk("r40_cause", o_trap_cause, 32'h8000_0003);
    chk("r40_tpc", o_trap_pc, 32'h40);
    clear_inputs();
    i_irq_timer = 1; i_irq_sw = 1; i_mie = 32'h88; i_mstatus_mie = 0; i_int_ok = 1;
    run_txn(0, 0, rpc);

    // MRET with low mepc bits cleared, redirect held off for 3 cycles
    clear_inputs();
    i_mret_req = 1; i_mepc = 32'h1237;
    run_txn(1, 3, rpc);
    chk("r41_rpc", rpc, 32'h1234);
    chk("r41_cause_kept", o_trap_cause, 32'h8000_0003);

    // External interrupt with a mode-01 mtvec
    clear_inputs();
    i_irq_ext = 1; i_mie = 32'h800; i_mstatus_mie = 1; i_int_ok = 1; i_mtvec = 32'h301;
    i_int_pc = 32'h88;
    run_txn(0, 0, rpc);
`ifdef VECTORED_MTVEC_EN
    chk("r43_rpc", rpc, 32'h32C);
`else
    chk("r43_rpc", rpc, 32'h300);
`endif
    chk("r43_cause", o_trap_cause, 32'h8000_000B);

    // Asynchronous reset in the middle of FLUSH
    clear_inputs();
    i_exc_valid = 1; i_exc_cause = 5'd9; i_exc_pc = 32'h500;
    @(posedge clk); #1;
    chk("r42_flush_before", 32'(o_flush), 1);
    i_exc_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("r42_busy", 32'(o_busy), 0);
    chk("r42_flush", 32'(o_flush), 0);
    chk("r42_redir", 32'(o_redirect_valid), 0);
    chk("r42_cause", o_trap_cause, 0);
    chk("r42_tpc", o_trap_pc, 0);
    chk("r42_rpc", o_redirect_pc, 0);
    m_cause = '0;
    m_pc    = '0;
    i_pipe_drained = 1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("r42_no_trap", 32'(o_trap_taken), 0);
      chk("r42_no_mret", 32'(o_mret_taken), 0);
      chk("r42_idle", 32'(o_busy), 0);
    end
    rst = 1'b0;

    // Random transactions
    quiet = 1'b0;
    for (int t = 0; t < 300; t++) begin
      random_idle_inputs();
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising edge), rst input 1 (async, active-high).
REQ-002 exc_valid input 1: synchronous exception request from the pipeline, level, sampled only in IDLE.
REQ-003 exc_cause input 5: exception code, 0..31.
REQ-004 exc_pc input 32: PC of the faulting instruction.
REQ-005 mret_req input 1: MRET reached commit, sampled only in IDLE.
REQ-006 irq_ext, irq_timer, irq_sw input 1 each: level-sensitive interrupt lines.
REQ-007 int_pc input 32: PC of the next unretired instruction, saved as mepc on an interrupt.
REQ-008 int_ok input 1: the pipeline is at an interruptible boundary this cycle.
REQ-009 mstatus_mie input 1; mie input 32; mtvec input 32; mepc input 32: current CSR values.
REQ-010 pipe_drained input 1: the pipeline is empty after a flush.
REQ-011 redirect_ready input 1: fetch accepts the redirect.
REQ-012 busy output 1: stall request to the pipeline, high whenever state is not IDLE.
REQ-013 flush output 1: kill all in-flight instructions.
REQ-014 trap_taken output 1, trap_cause output 32, trap_pc output 32: drive the CSR file.
REQ-015 mret_taken output 1: drives the CSR file.
REQ-016 redirect_valid output 1, redirect_pc output 32: new fetch PC.

Function
REQ-017 FSM states: IDLE, FLUSH, COMMIT, REDIRECT.
REQ-018 Event selection in IDLE, with priority exc_valid > mret_req > interrupt.
REQ-019 Interrupt pending set: irq_ext&mie[11], irq_sw&mie[3], irq_timer&mie[7]; taken only if mstatus_mie & int_ok.
REQ-020 Interrupt priority: ext (code 11) > sw (code 3) > timer (code 7).
REQ-021 Cause encoding: exceptions {27'b0, exc_cause}; interrupts {1'b1, 26'b0, code}.
REQ-022 Saved PC: exc_pc for exceptions, int_pc for interrupts.
REQ-023 On an accepted event in cycle N, cause, PC, kind and target SHALL be latched, and the state SHALL be FLUSH in cycle N+1.
REQ-024 FLUSH: flush=1 and busy=1; transition to COMMIT on the first cycle pipe_drained=1, which may be the first FLUSH cycle.
REQ-025 COMMIT lasts exactly 1 cycle: trap_taken=1 (trap) or mret_taken=1 (MRET), never both; trap_cause and trap_pc hold the latched values.
REQ-026 REDIRECT: redirect_valid=1 and redirect_pc=target, held stable until redirect_ready=1; return to IDLE in the cycle after the handshake.
REQ-027 Trap target (direct mode): {mtvec[31:2], 2'b00}.
REQ-028 MRET target: {mepc[31:2], 2'b00}, sampled in COMMIT so a same-cycle CSR update is not used.
REQ-029 Requests arriving outside IDLE SHALL be ignored, not queued; a still-asserted level is re-evaluated on return to IDLE.
REQ-030 trap_taken, mret_taken, flush and redirect_valid SHALL be 0 in IDLE.
REQ-031 trap_cause and trap_pc SHALL hold their last values outside COMMIT.
REQ-032 Target arithmetic is 32-bit and wraps modulo 2^32.

Reset
REQ-033 rst SHALL force IDLE immediately, including mid-FLUSH or mid-REDIRECT.
REQ-034 On rst, all outputs and latched registers SHALL be 0, and no trap_taken or mret_taken pulse SHALL be emitted.

Configuration
REQ-035 Macro VECTORED_MTVEC_EN, when defined: for interrupts with mtvec[1:0]==2'b01, target = {mtvec[31:2],2'b00} + 4*code.
REQ-036 With VECTORED_MTVEC_EN defined, exceptions always use the direct target.
REQ-037 VECTORED_MTVEC_EN undefined: mtvec[1:0] is ignored and all traps use the direct target.

Verification
REQ-038 exc_valid=1, exc_cause=2, exc_pc=0x100, mtvec=0x200, pipe_drained=1 -> flush in N+1, trap_taken pulse in N+2 with cause 0x2 and pc 0x100, redirect_pc=0x200.
REQ-039 Same cycle exc_valid=1, mret_req=1, irq_ext=1 -> exception path only; mret_taken never asserted.
REQ-040 irq_timer=irq_sw=1, mie=0x88, mstatus_mie=1, int_ok=1, int_pc=0x40 -> cause 0x80000003, trap_pc 0x40; repeat with mstatus_mie=0 -> no event.
REQ-041 mret_req=1, mepc=0x1237 -> mret_taken single pulse, redirect_pc=0x1234; redirect_ready held 0 for 3 cycles -> redirect_valid and redirect_pc stable throughout.
REQ-042 rst asserted during FLUSH with pipe_drained=0 -> IDLE, all outputs 0 asynchronously, no trap_taken pulse.
REQ-043 VECTORED_MTVEC_EN defined, mtvec=0x301, irq_ext -> redirect_pc=0x32C; undefined -> 0x300.
